// File: rtl/helix_reactor.sv
// helix_reactor: serial lane reducer (sum + XOR checksum) between the reservoir and the Loom.
// Optional threshold comparator with a fire pulse, enabled by defining HELIX_REACTOR_THRESH_EN.
module helix_reactor #(
    parameter int CONTEXT_W = 64,
    parameter int LANE_W    = 8,
    parameter int ACC_W     = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ctx_valid,
    output logic                 ctx_ready,
    input  logic [CONTEXT_W-1:0] ctx_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*ACC_W-1:0]   out_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     react_count
`ifdef HELIX_REACTOR_THRESH_EN
    ,
    input  logic [ACC_W-1:0]     thresh,
    output logic                 fire
`endif
);

    localparam int NLANES = CONTEXT_W / LANE_W;
    localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t               state;
    logic [CONTEXT_W-1:0] vec;
    logic [ACC_W-1:0]     sum;
    logic [LANE_W-1:0]    xr;
    logic [IDX_W-1:0]     idx;

    logic [LANE_W-1:0]    lane;
    logic [ACC_W-1:0]     sum_next;
    logic [LANE_W-1:0]    xor_next;

    // The latched vector is shifted down one lane per cycle, so the current lane is always the low slice.
    assign lane     = vec[LANE_W-1:0];
    assign sum_next = sum + ACC_W'(lane);
    assign xor_next = xr ^ lane;

    // NOTE: ctx_ready is a pure decode of state so upstream never sees a combinational path through us.
    assign ctx_ready = (state == IDLE);

    // NOTE: all state below is sequential and updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vec         <= '0;
            sum         <= '0;
            xr          <= '0;
            idx         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            react_count <= '0;
`ifdef HELIX_REACTOR_THRESH_EN
            fire        <= 1'b0;
`endif
        end else begin
`ifdef HELIX_REACTOR_THRESH_EN
            fire <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ctx_valid) begin
                        vec   <= ctx_data;
                        sum   <= '0;
                        xr    <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    vec <= vec >> LANE_W;
                    sum <= sum_next;
                    xr  <= xor_next;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        out_data  <= {sum_next, ACC_W'(xor_next)};
                        out_valid <= 1'b1;
                        state     <= EMIT;
`ifdef HELIX_REACTOR_THRESH_EN
                        fire      <= (sum_next > thresh);
`endif
                    end
                end
                EMIT: begin
                    // Returning to IDLE costs one cycle, so a new vector is never taken on the output handshake.
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        busy        <= 1'b0;
                        react_count <= react_count + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_helix_reactor.sv
// Randomized self-checking bench for helix_reactor against a lane-arithmetic reference model.
// Runs with CNT_W=4 so the reaction counter wraps within a short run.
module tb_helix_reactor;

    localparam int CONTEXT_W = 64;
    localparam int LANE_W    = 8;
    localparam int ACC_W     = 16;
    localparam int CNT_W     = 4;
    localparam int NLANES    = CONTEXT_W / LANE_W;

    logic                 clk;
    logic                 rst_n;
    logic                 ctx_valid;
    logic                 ctx_ready;
    logic [CONTEXT_W-1:0] ctx_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*ACC_W-1:0]   out_data;
    logic                 busy;
    logic [CNT_W-1:0]     react_count;
`ifdef HELIX_REACTOR_THRESH_EN
    logic [ACC_W-1:0]     thresh;
    logic                 fire;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [CNT_W-1:0] exp_count;

    helix_reactor #(
        .CONTEXT_W(CONTEXT_W),
        .LANE_W   (LANE_W),
        .ACC_W    (ACC_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctx_valid  (ctx_valid),
        .ctx_ready  (ctx_ready),
        .ctx_data   (ctx_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .react_count(react_count)
`ifdef HELIX_REACTOR_THRESH_EN
        ,
        .thresh     (thresh),
        .fire       (fire)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum and XOR over the lanes of the vector, sum modulo 2^ACC_W.
    function automatic logic [2*ACC_W-1:0] model(input logic [CONTEXT_W-1:0] v);
        logic [63:0] s;
        logic [63:0] x;
        logic [63:0] ln;
        s = 0;
        x = 0;
        for (int i = 0; i < NLANES; i++) begin
            ln = (64'(v) >> (i * LANE_W)) & ((64'd1 << LANE_W) - 1);
            s  = s + ln;
            x  = x ^ ln;
        end
        return {s[ACC_W-1:0], x[ACC_W-1:0]};
    endfunction

    task automatic run_vec(input logic [CONTEXT_W-1:0] v, input int hold, input logic [ACC_W-1:0] th);
        logic [2*ACC_W-1:0] exp;
        logic [2*ACC_W-1:0] held;
        int n;
        exp = model(v);
        check("idle_ready", ctx_ready, 1);
        ctx_valid = 1'b1;
        ctx_data  = v;
        out_ready = (hold == 0);
`ifdef HELIX_REACTOR_THRESH_EN
        thresh = th;
`endif
        step();
        ctx_valid = 1'b0;
        ctx_data  = {$urandom, $urandom};
        n = 0;
        while (!out_valid && n < 40) begin
            check("accum_ready", ctx_ready, 0);
            check("accum_busy", busy, 1);
`ifdef HELIX_REACTOR_THRESH_EN
            check("accum_fire", fire, 0);
`endif
            ctx_valid = 1'($urandom_range(0, 1));
            ctx_data  = {$urandom, $urandom};
            step();
            n++;
        end
        check("latency", n, NLANES);
        check("out_data", out_data, exp);
        check("emit_busy", busy, 1);
`ifdef HELIX_REACTOR_THRESH_EN
        check("fire_first", fire, exp[2*ACC_W-1:ACC_W] > th);
`endif
        held = out_data;
        repeat (hold) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, held);
            check("bp_ready", ctx_ready, 0);
            check("bp_count", react_count, exp_count);
`ifdef HELIX_REACTOR_THRESH_EN
            check("bp_fire", fire, 0);
`endif
        end
        out_ready = 1'b1;
        step();
        exp_count = exp_count + 1'b1;
        check("done_valid", out_valid, 0);
        check("done_count", react_count, exp_count);
        check("done_ready", ctx_ready, 1);
        check("done_busy", busy, 0);
`ifdef HELIX_REACTOR_THRESH_EN
        check("done_fire", fire, 0);
`endif
        ctx_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        if (th == 0) th = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, ctx_ready, 1);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_count"}, react_count, 0);
`ifdef HELIX_REACTOR_THRESH_EN
        check({tag, "_fire"}, fire, 0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        ctx_valid = 1'b0;
        ctx_data  = '0;
        out_ready = 1'b0;
        exp_count = '0;
`ifdef HELIX_REACTOR_THRESH_EN
        thresh = '0;
`endif
        #12;
        check_reset_values("por");
        rst_n = 1'b1;
        step();

        run_vec(64'h0807060504030201, 0, 16'h0023);
        run_vec(64'h0807060504030201, 0, 16'h0024);
        run_vec(64'hFFFF_FFFF_FFFF_FFFF, 0, 16'($urandom));
        run_vec(64'h0807060504030201, 20, 16'h0010);

        // Abort in cycle 4 of an accumulation; nothing may come out for that vector.
        ctx_valid = 1'b1;
        ctx_data  = {$urandom, $urandom};
        out_ready = 1'b1;
        step();
        ctx_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        step();
        rst_n = 1'b1;
        exp_count = '0;
        repeat (12) step();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_count", react_count, 0);
        run_vec(64'h01, 0, 16'h0000);

        for (int k = 0; k < 30; k++) begin
            run_vec({$urandom, $urandom}, (k % 4 == 0) ? 0 : int'($urandom_range(0, 5)),
                    16'($urandom_range(0, 2100)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
